// File: rtl/fc3_bias_sequencer.sv
// -----------------------------------------------------------------------------
// fc3_bias_sequencer
//
// Walks the FC3 bias ROM one output batch at a time. For each batch the packed
// bias word is read, the accumulator's partial sums for that batch are taken
// in, every lane gets its bias added with signed saturation, and the result is
// offered downstream together with its batch index. After the last batch is
// accepted downstream a single-cycle done pulse is raised. This block is the
// only master of the bias ROM.
//
// Ports
//   clk        clock
//   rstn       synchronous reset, active low (aborts a pass immediately)
//   start      begin a full pass; only looked at while idle
//   busy       high in every state except idle
//   done       one-cycle pulse after the last batch is accepted downstream
//   rom_aa     ROM address (batch index); holds its last driven value
//   rom_cena   ROM read enable, active low, low for exactly one cycle per batch
//   rom_qa     ROM data, registered: valid the cycle after rom_cena was low
//   acc_valid  partial sums for the current batch are on acc_data
//   acc_ready  sequencer is waiting for partial sums
//   acc_data   packed signed partial sums, lane 0 in the MSBs
//   out_valid  out_data / out_batch hold a biased result
//   out_ready  downstream accepts the result
//   out_data   packed signed biased, saturated results, lane 0 in the MSBs
//   out_batch  batch index belonging to out_data
//   dbg_state  current FSM state encoding, for observation only
//
// Handshakes (acc_* and out_*): a transfer happens on a rising clk edge where
// valid and ready are both high. Once out_valid rises, out_data and out_batch
// stay unchanged until that transfer. acc_valid while acc_ready is low and
// out_ready while out_valid is low have no effect.
// -----------------------------------------------------------------------------
module fc3_bias_sequencer #(
  parameter int N_BATCH = 5,
  parameter int N_LANE  = 5,
  parameter int W_ADDR  = 3,
  parameter int W_BIAS  = 34,
  parameter int W_ACC   = 40
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [W_ADDR-1:0]          rom_aa,
  output logic                       rom_cena,
  input  logic [N_LANE*W_BIAS-1:0]   rom_qa,
  input  logic                       acc_valid,
  output logic                       acc_ready,
  input  logic [N_LANE*W_ACC-1:0]    acc_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_LANE*W_ACC-1:0]    out_data,
  output logic [W_ADDR-1:0]          out_batch,
  output logic [2:0]                 dbg_state
);

  localparam logic [W_ADDR-1:0] LAST_BATCH = W_ADDR'(N_BATCH - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_CAPTURE  = 3'd2,
    S_WAIT_ACC = 3'd3,
    S_OUT      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t                     state;
  state_t                     state_d;
  logic [W_ADDR-1:0]          batch;
  logic [W_ADDR-1:0]          rom_aa_q;
  logic [N_LANE*W_BIAS-1:0]   bias_reg;
  logic [N_LANE*W_ACC-1:0]    out_data_q;
  logic [W_ADDR-1:0]          out_batch_q;
  logic [N_LANE*W_ACC-1:0]    sat_sum;
  logic                       acc_hs;
  logic                       out_hs;
  logic                       last_batch;

  // ---------------------------------------------------------------------------
  // Per-lane bias add. The bias is sign-extended to the accumulator width and
  // the sum is formed one bit wider, so overflow shows up as the top two bits
  // of the sum disagreeing; the top bit then tells which rail to clamp to.
  // Each lane is handled on its own; no carry crosses a lane boundary.
  // ---------------------------------------------------------------------------
  function automatic logic [W_ACC-1:0] sat_add(input logic [W_ACC-1:0]  a,
                                               input logic [W_BIAS-1:0] b);
    logic [W_ACC:0] s;
    s = {a[W_ACC-1], a} + {{(W_ACC + 1 - W_BIAS){b[W_BIAS-1]}}, b};
    if (s[W_ACC] == s[W_ACC-1]) begin
      return s[W_ACC-1:0];
    end else if (s[W_ACC]) begin
      return {1'b1, {(W_ACC-1){1'b0}}};
    end else begin
      return {1'b0, {(W_ACC-1){1'b1}}};
    end
  endfunction

  always_comb begin
    sat_sum = '0;
    for (int i = 0; i < N_LANE; i++) begin
      sat_sum[(N_LANE-i)*W_ACC-1 -: W_ACC] =
        sat_add(acc_data[(N_LANE-i)*W_ACC-1 -: W_ACC],
                bias_reg[(N_LANE-i)*W_BIAS-1 -: W_BIAS]);
    end
  end

  assign acc_hs     = acc_valid && acc_ready;
  assign out_hs     = out_valid && out_ready;
  assign last_batch = (batch == LAST_BATCH);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and state-decoded outputs. Every control output is a pure
  // function of the state, so acc_ready and out_valid can never overlap and
  // rom_cena is low only while fetching.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state;
    busy      = 1'b1;
    done      = 1'b0;
    rom_cena  = 1'b1;
    acc_ready = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        rom_cena = 1'b0;
        state_d  = S_CAPTURE;
      end
      S_CAPTURE: begin
        // rom_qa carries the word addressed during the fetch cycle.
        state_d = S_WAIT_ACC;
      end
      S_WAIT_ACC: begin
        acc_ready = 1'b1;
        if (acc_valid) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = last_batch ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        // start is deliberately not examined here; it must be seen in idle.
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. rom_aa is loaded when moving into the fetch state so
  // it equals the batch index during the read and then simply holds, rather
  // than following batch back to zero at the end of a pass.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      batch       <= '0;
      rom_aa_q    <= '0;
      bias_reg    <= '0;
      out_data_q  <= '0;
      out_batch_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            batch    <= '0;
            rom_aa_q <= '0;
          end
        end
        S_CAPTURE: begin
          bias_reg <= rom_qa;
        end
        S_WAIT_ACC: begin
          if (acc_hs) begin
            out_data_q  <= sat_sum;
            out_batch_q <= batch;
          end
        end
        S_OUT: begin
          if (out_hs && !last_batch) begin
            batch    <= batch + W_ADDR'(1);
            rom_aa_q <= batch + W_ADDR'(1);
          end
        end
        S_DONE: begin
          batch <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign rom_aa    = rom_aa_q;
  assign out_data  = out_data_q;
  assign out_batch = out_batch_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_fc3_bias_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fc3_bias_sequencer
//
// Drives complete FC3 bias passes through fc3_bias_sequencer with a registered
// ROM model, randomized partial sums, randomized and targeted stalls on both
// handshakes, a saturation pass, a mid-pass start pulse and a mid-pass reset.
// Expected results are computed lane by lane with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_fc3_bias_sequencer;

  localparam int N_BATCH = 5;
  localparam int N_LANE  = 5;
  localparam int W_ADDR  = 3;
  localparam int W_BIAS  = 34;
  localparam int W_ACC   = 40;
  localparam int WD      = N_LANE * W_ACC;
  localparam int WR      = N_LANE * W_BIAS;

  localparam longint MAXV = (64'sd1 <<< (W_ACC - 1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (W_ACC - 1));

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic              busy;
  logic              done;
  logic [W_ADDR-1:0] rom_aa;
  logic              rom_cena;
  logic [WR-1:0]     rom_qa;
  logic              acc_valid;
  logic              acc_ready;
  logic [WD-1:0]     acc_data;
  logic              out_valid;
  logic              out_ready;
  logic [WD-1:0]     out_data;
  logic [W_ADDR-1:0] out_batch;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  fc3_bias_sequencer #(
    .N_BATCH(N_BATCH), .N_LANE(N_LANE), .W_ADDR(W_ADDR),
    .W_BIAS(W_BIAS), .W_ACC(W_ACC)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .rom_aa(rom_aa), .rom_cena(rom_cena), .rom_qa(rom_qa),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_batch(out_batch), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int excl_cnt = 0;

  logic [WR-1:0]     rom_mem [N_BATCH];
  logic [WD-1:0]     acc_arr [N_BATCH];
  logic [WD-1:0]     obs_arr [N_BATCH];
  int                da_arr  [N_BATCH];
  int                do_arr  [N_BATCH];
  logic [WD-1:0]     exp_q[$];
  logic [W_ADDR-1:0] expb_q[$];
  logic [W_ADDR-1:0] rom_addr_q[$];

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Registered ROM; outside a read the data bus carries noise so a capture on
  // the wrong cycle cannot go unnoticed.
  always @(posedge clk) begin
    if (!rom_cena) begin
      rom_qa <= (int'(rom_aa) < N_BATCH) ? rom_mem[rom_aa] : '0;
    end else begin
      rom_qa <= WR'(rnd256());
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rstn && !rom_cena) rom_addr_q.push_back(rom_aa);
    if (done) done_cnt++;
    if (acc_ready && out_valid) excl_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Checking and report
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic report();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  initial begin
    #2000000;
    check("watchdog", 0, 1);
    report();
  end

  // ---------------------------------------------------------------------------
  // Reference model: each lane is a signed integer; add, clamp to the W_ACC
  // signed range, repack.
  // ---------------------------------------------------------------------------
  function automatic logic [WD-1:0] model(input logic [WD-1:0] acc, input logic [WR-1:0] bias);
    logic [WD-1:0]            r;
    logic signed [W_ACC-1:0]  a;
    logic signed [W_BIAS-1:0] b;
    longint                   s;
    r = '0;
    for (int i = 0; i < N_LANE; i++) begin
      a = acc[(N_LANE-i)*W_ACC-1 -: W_ACC];
      b = bias[(N_LANE-i)*W_BIAS-1 -: W_BIAS];
      s = longint'(a) + longint'(b);
      if (s > MAXV) s = MAXV;
      else if (s < MINV) s = MINV;
      r[(N_LANE-i)*W_ACC-1 -: W_ACC] = s[W_ACC-1:0];
    end
    return r;
  endfunction

  // Lanes biased toward the rails so that saturation happens regularly.
  function automatic logic [WD-1:0] rnd_acc();
    logic [WD-1:0] r;
    longint        v;
    r = '0;
    for (int i = 0; i < N_LANE; i++) begin
      case ($urandom_range(0, 3))
        0:       v = MAXV - longint'($urandom_range(0, 1 << 20));
        1:       v = MINV + longint'($urandom_range(0, 1 << 20));
        default: v = {$urandom, $urandom};
      endcase
      r[(N_LANE-i)*W_ACC-1 -: W_ACC] = v[W_ACC-1:0];
    end
    return r;
  endfunction

  task automatic fill_random(input int da_max, input int do_max);
    for (int b = 0; b < N_BATCH; b++) begin
      rom_mem[b] = WR'(rnd256());
      acc_arr[b] = rnd_acc();
      da_arr[b]  = $urandom_range(0, da_max);
      do_arr[b]  = $urandom_range(0, do_max);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one pass. Called at a negedge with the DUT idle. Stalls come from
  // da_arr/do_arr; mid_start pulses start while busy and during done;
  // rst_b3 resets the DUT in the first waiting cycle of batch 3.
  // ---------------------------------------------------------------------------
  task automatic do_pass(input bit mid_start, input bit rst_b3);
    int                k0;
    int                exp_cyc;
    int                d0;
    logic [WD-1:0]     exp_w;
    logic [W_ADDR-1:0] exp_b;
    d0 = done_cnt;
    rom_addr_q.delete();
    exp_q.delete();
    expb_q.delete();
    exp_cyc = 1;
    for (int b = 0; b < N_BATCH; b++) begin
      exp_q.push_back(model(acc_arr[b], rom_mem[b]));
      expb_q.push_back(W_ADDR'(b));
      exp_cyc += 4 + da_arr[b] + do_arr[b];
    end

    start = 1'b1;
    k0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);

    for (int b = 0; b < N_BATCH; b++) begin
      check("fetch_cena", rom_cena, 0);
      check("fetch_aa", rom_aa, b);
      check("fetch_accr", acc_ready, 0);
      if (b == 0) check("fetch_cyc", cyc, k0 + 1);
      @(negedge clk);
      check("cap_cena", rom_cena, 1);
      check("cap_accr", acc_ready, 0);
      acc_valid = 1'($urandom_range(0, 1));
      acc_data  = WD'(rnd256());
      @(negedge clk);
      check("wait_accr", acc_ready, 1);
      check("wait_outv", out_valid, 0);
      if (b == 0) check("accr_cyc", cyc, k0 + 3);

      if (rst_b3 && b == 3) begin
        rstn      = 1'b0;
        acc_valid = 1'b1;
        acc_data  = acc_arr[b];
        @(negedge clk);
        rstn      = 1'b1;
        acc_valid = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        check("rst_accr", acc_ready, 0);
        check("rst_outv", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_cena", rom_cena, 1);
        check("rst_aa", rom_aa, 0);
        check("rst_odata", out_data, 0);
        check("rst_obatch", out_batch, 0);
        @(negedge clk);
        check("rst_idle", busy, 0);
        check("rst_no_done", done_cnt - d0, 0);
        return;
      end

      for (int d = 0; d < da_arr[b]; d++) begin
        acc_valid = 1'b0;
        acc_data  = WD'(rnd256());
        start     = (mid_start && d == 2);
        @(negedge clk);
        check("stall_accr", acc_ready, 1);
        check("stall_cena", rom_cena, 1);
      end
      start     = 1'b0;
      acc_valid = 1'b1;
      acc_data  = acc_arr[b];
      @(negedge clk);
      acc_valid = 1'($urandom_range(0, 1));
      acc_data  = WD'(rnd256());
      exp_w = exp_q.pop_front();
      exp_b = expb_q.pop_front();
      obs_arr[b] = out_data;
      check("out_valid", out_valid, 1);
      check("out_accr", acc_ready, 0);
      check("out_data", out_data, exp_w);
      check("out_batch", out_batch, exp_b);

      for (int d = 0; d < do_arr[b]; d++) begin
        out_ready = 1'b0;
        start     = (mid_start && d == 1);
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, exp_w);
        check("hold_batch", out_batch, exp_b);
        check("hold_cena", rom_cena, 1);
        check("hold_accr", acc_ready, 0);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
    end

    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_cyc", cyc, k0 + exp_cyc);
    start = mid_start;
    @(negedge clk);
    start = 1'b0;
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    @(negedge clk);
    check("stay_idle", busy, 0);
    check("done_once", done_cnt - d0, 1);
    check("rom_reads", rom_addr_q.size(), N_BATCH);
    for (int b = 0; b < N_BATCH && b < rom_addr_q.size(); b++) begin
      check("rom_addr", rom_addr_q[b], b);
    end
    check("aa_hold", rom_aa, N_BATCH - 1);
    out_ready = 1'b0;
    acc_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    logic [W_ACC-1:0] lane;
    longint           v;
    rstn      = 1'b0;
    start     = 1'b0;
    acc_valid = 1'b0;
    acc_data  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_cena", rom_cena, 1);
    check("reset_aa", rom_aa, 0);
    check("reset_accr", acc_ready, 0);
    check("reset_outv", out_valid, 0);
    check("reset_odata", out_data, 0);
    check("reset_obatch", out_batch, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Zero partial sums, no stalls: results are the sign-extended biases.
    fill_random(0, 0);
    for (int b = 0; b < N_BATCH; b++) acc_arr[b] = '0;
    do_pass(1'b0, 1'b0);

    // Downstream backpressure on batch 2.
    fill_random(0, 0);
    do_arr[2] = 10;
    do_pass(1'b0, 1'b0);

    // Saturation at both rails on batch 1, small lanes elsewhere.
    fill_random(1, 1);
    for (int i = 2; i < N_LANE; i++) begin
      v = longint'($urandom_range(0, 2000)) - 1000;
      acc_arr[1][(N_LANE-i)*W_ACC-1 -: W_ACC] = v[W_ACC-1:0];
      rom_mem[1][(N_LANE-i)*W_BIAS-1 -: W_BIAS] = W_BIAS'(v * 3);
    end
    acc_arr[1][WD-1 -: W_ACC]          = MAXV[W_ACC-1:0];
    rom_mem[1][WR-1 -: W_BIAS]         = W_BIAS'(64'sd750085376);
    acc_arr[1][WD-W_ACC-1 -: W_ACC]    = MINV[W_ACC-1:0];
    rom_mem[1][WR-W_BIAS-1 -: W_BIAS]  = W_BIAS'(-64'sd616584640);
    do_pass(1'b0, 1'b0);
    check("sat_hi", obs_arr[1][WD-1 -: W_ACC], 40'h7F_FFFF_FFFF);
    check("sat_lo", obs_arr[1][WD-W_ACC-1 -: W_ACC], 40'h80_0000_0000);
    for (int i = 2; i < N_LANE; i++) begin
      lane = acc_arr[1][(N_LANE-i)*W_ACC-1 -: W_ACC];
      v = longint'($signed(lane)) * 4;
      check("sat_other", obs_arr[1][(N_LANE-i)*W_ACC-1 -: W_ACC], v[W_ACC-1:0]);
    end

    // Accumulator late by 7 cycles every batch, start pulsed while busy.
    fill_random(0, 2);
    for (int b = 0; b < N_BATCH; b++) da_arr[b] = 7;
    do_pass(1'b1, 1'b0);

    // Reset while waiting on batch 3, then a clean pass from batch 0.
    fill_random(2, 2);
    do_pass(1'b0, 1'b1);
    fill_random(2, 2);
    do_pass(1'b0, 1'b0);

    // Random passes.
    for (int p = 0; p < 4; p++) begin
      fill_random(3, 3);
      do_pass(1'($urandom_range(0, 1)), 1'b0);
    end

    check("valid_ready_overlap", excl_cnt, 0);
    report();
  end

endmodule
